// File: rtl/alarm_sched_if.sv
// Alarm sequencer bus: button/tick/time inputs, setpoint/display/status outputs.
// master = stimulus side, slave = alarm_sched_ctrl.
interface alarm_sched_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] time_d0;
  logic [3:0] time_d1;
  logic [3:0] time_d2;
  logic [3:0] time_d3;
  logic [3:0] alm_d0;
  logic [3:0] alm_d1;
  logic [3:0] alm_d2;
  logic [3:0] alm_d3;
  logic [3:0] disp_d0;
  logic [3:0] disp_d1;
  logic [3:0] disp_d2;
  logic [3:0] disp_d3;
  logic [3:0] blank;
  logic       ring;
  logic       armed;
  logic [2:0] state;

  modport master (
    output tick_1hz, btn_mode, btn_inc,
    output time_d0, time_d1, time_d2, time_d3,
    input  alm_d0, alm_d1, alm_d2, alm_d3,
    input  disp_d0, disp_d1, disp_d2, disp_d3,
    input  blank, ring, armed, state
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_inc,
    input  time_d0, time_d1, time_d2, time_d3,
    output alm_d0, alm_d1, alm_d2, alm_d3,
    output disp_d0, disp_d1, disp_d2, disp_d3,
    output blank, ring, armed, state
  );
endinterface

// File: rtl/alarm_sched_ctrl.sv
// Alarm clock mode sequencer: setpoint entry, match, ring/snooze, display mux.
// Ports: clk, reset (sync, active-high), bus (alarm_sched_if.slave).
module alarm_sched_ctrl #(
  parameter int unsigned RING_SEC   = 30,
  parameter int unsigned SNOOZE_SEC = 9
) (
  input logic         clk,
  input logic         reset,
  alarm_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SET_MIN = 3'd1,
    SET_SEC = 3'd2,
    ARMED   = 3'd3,
    RINGING = 3'd4,
    SNOOZE  = 3'd5
  } st_t;

  localparam logic [7:0] RING_L = 8'(RING_SEC);
  localparam logic [7:0] SNZ_L  = 8'(SNOOZE_SEC);

  st_t        st;
  logic [3:0] a0, a1, a2, a3;
  logic [3:0] q0, q1, q2, q3;
  logic [3:0] blank_q;
  logic       ring_q;
  logic       armed_q;
  logic       blink_ph;
  logic [7:0] ring_cnt;
  logic [7:0] snz_cnt;

  logic       match;
  logic [3:0] mu_n, mt_n, su_n, st_n;

  // BCD +1 on a 00..59 pair, wrapping 59 -> 00.
  always_comb begin
    match = (bus.time_d0 == a0) && (bus.time_d1 == a1) &&
            (bus.time_d2 == a2) && (bus.time_d3 == a3);
    mu_n = a2 + 4'd1;
    mt_n = a3;
    if (a2 == 4'd9) begin
      mu_n = 4'd0;
      mt_n = (a3 == 4'd5) ? 4'd0 : a3 + 4'd1;
    end
    su_n = a0 + 4'd1;
    st_n = a1;
    if (a0 == 4'd9) begin
      su_n = 4'd0;
      st_n = (a1 == 4'd5) ? 4'd0 : a1 + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= IDLE;
      a0       <= '0;
      a1       <= '0;
      a2       <= '0;
      a3       <= '0;
      q0       <= '0;
      q1       <= '0;
      q2       <= '0;
      q3       <= '0;
      blank_q  <= '0;
      ring_q   <= 1'b0;
      armed_q  <= 1'b0;
      blink_ph <= 1'b0;
      ring_cnt <= '0;
      snz_cnt  <= '0;
    end else begin
      // Entering a set mode restarts blink; that clear overrides the toggle.
      if (bus.tick_1hz) blink_ph <= ~blink_ph;

      unique case (st)
        IDLE: begin
          if (bus.btn_mode) begin
            st       <= SET_MIN;
            blink_ph <= 1'b0;
          end
        end
        SET_MIN: begin
          if (bus.btn_mode) begin
            st       <= SET_SEC;
            blink_ph <= 1'b0;
          end else if (bus.btn_inc) begin
            a2 <= mu_n;
            a3 <= mt_n;
          end
        end
        SET_SEC: begin
          if (bus.btn_mode) st <= ARMED;
          else if (bus.btn_inc) begin
            a0 <= su_n;
            a1 <= st_n;
          end
        end
        ARMED: begin
          if (bus.btn_mode) st <= IDLE;
          else if (match) begin
            st       <= RINGING;
            ring_cnt <= '0;
          end
        end
        RINGING: begin
          if (bus.btn_mode) st <= IDLE;
          else if (bus.btn_inc) begin
            st      <= SNOOZE;
            snz_cnt <= SNZ_L;
          end else if (bus.tick_1hz) begin
            ring_cnt <= ring_cnt + 8'd1;
            if (ring_cnt + 8'd1 >= RING_L) st <= IDLE;
          end
        end
        SNOOZE: begin
          if (bus.btn_mode) st <= IDLE;
          else if (bus.tick_1hz) begin
            snz_cnt <= snz_cnt - 8'd1;
            if (snz_cnt <= 8'd1) begin
              st       <= RINGING;
              ring_cnt <= '0;
            end
          end
        end
        default: st <= IDLE;
      endcase

      // Outputs follow the current state one clk later.
      if (st == SET_MIN || st == SET_SEC) begin
        q0 <= a0;
        q1 <= a1;
        q2 <= a2;
        q3 <= a3;
      end else begin
        q0 <= bus.time_d0;
        q1 <= bus.time_d1;
        q2 <= bus.time_d2;
        q3 <= bus.time_d3;
      end
      if (st == SET_MIN && blink_ph)      blank_q <= 4'b1100;
      else if (st == SET_SEC && blink_ph) blank_q <= 4'b0011;
      else                                blank_q <= 4'b0000;
      ring_q  <= (st == RINGING);
      armed_q <= (st == ARMED) || (st == RINGING) || (st == SNOOZE);
    end
  end

  assign bus.alm_d0  = a0;
  assign bus.alm_d1  = a1;
  assign bus.alm_d2  = a2;
  assign bus.alm_d3  = a3;
  assign bus.disp_d0 = q0;
  assign bus.disp_d1 = q1;
  assign bus.disp_d2 = q2;
  assign bus.disp_d3 = q3;
  assign bus.blank   = blank_q;
  assign bus.ring    = ring_q;
  assign bus.armed   = armed_q;
  assign bus.state   = st;

endmodule

// File: tb/tb_alarm_sched_ctrl.sv
// Directed bench for alarm_sched_ctrl: mode walk, setpoint entry, ring/snooze,
// priority, blink and reset.
module tb_alarm_sched_ctrl;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  alarm_sched_if bus ();

  alarm_sched_ctrl #(.RING_SEC(30), .SNOOZE_SEC(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mode_p();
    bus.btn_mode = 1'b1;
    step();
    bus.btn_mode = 1'b0;
  endtask

  task automatic inc_p();
    bus.btn_inc = 1'b1;
    step();
    bus.btn_inc = 1'b0;
  endtask

  task automatic tick_p();
    bus.tick_1hz = 1'b1;
    step();
    bus.tick_1hz = 1'b0;
    step();
  endtask

  task automatic set_time(input logic [15:0] t);
    bus.time_d3 = t[15:12];
    bus.time_d2 = t[11:8];
    bus.time_d1 = t[7:4];
    bus.time_d0 = t[3:0];
  endtask

  function automatic logic [15:0] alm();
    return {bus.alm_d3, bus.alm_d2, bus.alm_d1, bus.alm_d0};
  endfunction

  function automatic logic [15:0] disp();
    return {bus.disp_d3, bus.disp_d2, bus.disp_d1, bus.disp_d0};
  endfunction

  initial begin
    int k;
    n_chk  = 0;
    n_fail = 0;
    reset        = 1'b1;
    bus.tick_1hz = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    set_time(16'h1234);
    step();
    step();
    reset = 1'b0;

    chk("rst_state", 16'(bus.state), 16'd0);
    chk("rst_alm", alm(), 16'h0000);
    chk("rst_disp", disp(), 16'h0000);
    chk("rst_blank", 16'(bus.blank), 16'h0);
    chk("rst_ring", 16'(bus.ring), 16'd0);
    chk("rst_armed", 16'(bus.armed), 16'd0);

    // Mode walk.
    inc_p();
    chk("idle_inc_ign", 16'(bus.state), 16'd0);
    mode_p();
    chk("walk_setmin", 16'(bus.state), 16'd1);
    mode_p();
    chk("walk_setsec", 16'(bus.state), 16'd2);
    mode_p();
    chk("walk_armed", 16'(bus.state), 16'd3);
    step();
    chk("walk_armed_out", 16'(bus.armed), 16'd1);
    chk("walk_alm", alm(), 16'h0000);
    chk("walk_disp_time", disp(), 16'h1234);
    mode_p();
    chk("disarm", 16'(bus.state), 16'd0);

    // Minutes entry across 60 increments.
    mode_p();
    for (int i = 1; i <= 60; i++) begin
      inc_p();
      k = i % 60;
      chk($sformatf("min_inc%0d", i), alm(),
          {4'(k / 10), 4'(k % 10), 8'h00});
    end
    step();
    chk("setmin_disp_alm", disp(), 16'h0000);

    // Set 01:05 and arm.
    inc_p();
    mode_p();
    for (int i = 0; i < 5; i++) inc_p();
    chk("alm_0105", alm(), 16'h0105);
    step();
    chk("setsec_disp_alm", disp(), 16'h0105);
    set_time(16'h0104);
    mode_p();
    step();
    step();
    chk("armed_nomatch", 16'(bus.state), 16'd3);
    chk("armed_noring", 16'(bus.ring), 16'd0);
    set_time(16'h0105);
    step();
    chk("match_state", 16'(bus.state), 16'd4);
    chk("match_ring_lag", 16'(bus.ring), 16'd0);
    step();
    chk("match_ring", 16'(bus.ring), 16'd1);
    chk("match_armed", 16'(bus.armed), 16'd1);

    // Snooze then re-ring, then ring timeout.
    inc_p();
    chk("snooze_state", 16'(bus.state), 16'd5);
    step();
    chk("snooze_ring", 16'(bus.ring), 16'd0);
    chk("snooze_armed", 16'(bus.armed), 16'd1);
    for (int i = 0; i < 8; i++) tick_p();
    chk("snooze_8tick", 16'(bus.state), 16'd5);
    tick_p();
    chk("snooze_rering", 16'(bus.state), 16'd4);
    chk("snooze_rering_out", 16'(bus.ring), 16'd1);
    for (int i = 0; i < 29; i++) tick_p();
    chk("ring_29tick", 16'(bus.state), 16'd4);
    tick_p();
    chk("ring_timeout", 16'(bus.state), 16'd0);
    chk("ring_timeout_out", 16'(bus.ring), 16'd0);
    chk("ring_timeout_armed", 16'(bus.armed), 16'd0);

    // Re-arm while matching; mode and inc together in RINGING.
    mode_p();
    mode_p();
    mode_p();
    chk("rearm_armed", 16'(bus.state), 16'd3);
    step();
    chk("rearm_ringing", 16'(bus.state), 16'd4);
    bus.btn_mode = 1'b1;
    bus.btn_inc  = 1'b1;
    step();
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    chk("prio_state", 16'(bus.state), 16'd0);
    step();
    chk("prio_ring", 16'(bus.ring), 16'd0);

    // Blink in SET_SEC and seconds wrap.
    set_time(16'h2347);
    mode_p();
    mode_p();
    step();
    chk("blink_init", 16'(bus.blank), 16'h0);
    tick_p();
    chk("blink_on", 16'(bus.blank), 16'h3);
    tick_p();
    chk("blink_off", 16'(bus.blank), 16'h0);
    tick_p();
    chk("blink_on2", 16'(bus.blank), 16'h3);
    for (int i = 0; i < 54; i++) inc_p();
    chk("sec_59", alm(), 16'h0159);
    inc_p();
    chk("sec_wrap", alm(), 16'h0100);

    // Reset mid-operation.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_state", 16'(bus.state), 16'd0);
    chk("mid_rst_alm", alm(), 16'h0000);
    chk("mid_rst_disp", disp(), 16'h0000);
    chk("mid_rst_blank", 16'(bus.blank), 16'h0);
    chk("mid_rst_ring", 16'(bus.ring), 16'd0);
    chk("mid_rst_armed", 16'(bus.armed), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
